// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the parallel-to-serial feeder: FSM encoding,
// counter sizing helper and the default word width.
package serial_bit_feeder_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Word handshake plus serial output bundle of the feeder; the slave side is the
// feeder itself, the master side is the word producer / bit consumer.
interface serial_bit_feeder_if
  import serial_bit_feeder_pkg::*;
#(
  parameter int W = DEFAULT_W
);

  logic [W-1:0] DIN;
  logic         DIN_VALID;
  logic         DIN_READY;
  logic         SO;
  logic         SO_VALID;
  logic         WORD_DONE;
  logic         BUSY;

  modport slave (
    input  DIN, DIN_VALID,
    output DIN_READY, SO, SO_VALID, WORD_DONE, BUSY
  );

  modport master (
    output DIN, DIN_VALID,
    input  DIN_READY, SO, SO_VALID, WORD_DONE, BUSY
  );

endinterface

// File: rtl/serial_bit_feeder.sv
// Serialises handshaken parallel words one bit per clock; a one-word holding
// buffer behind the shifter lets consecutive words stream without a gap.
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int   W         = DEFAULT_W,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  serial_bit_feeder_if.slave  bus
);

  localparam int             CW       = cnt_width(W);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hold_full_q, hold_full_d;
  logic [W-1:0]    hold_q, hold_d;
  logic [W-1:0]    sh_q, sh_d;
  logic            so_q, so_d;
  logic            so_vld_q, so_vld_d;
  logic            done_q, done_d;
  logic            accept;
  logic            load;

  function automatic logic lead_bit(input logic [W-1:0] w);
    return MSB_FIRST ? w[W-1] : w[0];
  endfunction

  // Drop the bit just emitted so the next one sits at the lead position.
  function automatic logic [W-1:0] advance(input logic [W-1:0] w);
    return MSB_FIRST ? {w[W-2:0], 1'b0} : {1'b0, w[W-1:1]};
  endfunction

  assign bus.DIN_READY = ~hold_full_q & ~RST;
  assign accept        = bus.DIN_VALID & bus.DIN_READY;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    so_d        = IDLE_BIT;
    so_vld_d    = 1'b0;
    done_d      = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      SHIFT: begin
        // cnt_q == 0 in SHIFT marks the edge after a word's last bit.
        if (cnt_q != '0) begin
          so_d     = lead_bit(sh_q);
          sh_d     = advance(sh_q);
          so_vld_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
          end
        end else if (hold_full_q) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      so_d        = lead_bit(hold_q);
      sh_d        = advance(hold_q);
      so_vld_d    = 1'b1;
      cnt_d       = CNT_ONE;
      hold_full_d = 1'b0;
      state_d     = SHIFT;
    end

    // Never coincides with load: DIN_READY is low while the hold is full.
    if (accept) begin
      hold_d      = bus.DIN;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      so_q        <= IDLE_BIT;
      so_vld_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      so_q        <= so_d;
      so_vld_q    <= so_vld_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge CLK) begin
    hold_q <= hold_d;
    sh_q   <= sh_d;
  end

  assign bus.SO        = so_q;
  assign bus.SO_VALID  = so_vld_q;
  assign bus.WORD_DONE = done_q;
  assign bus.BUSY      = (state_q == SHIFT) | hold_full_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: one MSB-first and one LSB-first
// instance share clock and reset; each scenario task checks its own vectors.
module tb_serial_bit_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_bit_feeder_if #(.W(8)) bus_m ();
  serial_bit_feeder_if #(.W(8)) bus_l ();

  serial_bit_feeder #(.W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .CLK (clk),
    .RST (rst),
    .bus (bus_m)
  );

  serial_bit_feeder #(.W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .CLK (clk),
    .RST (rst),
    .bus (bus_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus_m.SO !== 1'b0) begin n_fail++; $display("FAIL reset_so: got %b want 0", bus_m.SO); end
    n_cmp++; if (bus_m.SO_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_so_valid: got %b want 0", bus_m.SO_VALID); end
    n_cmp++; if (bus_m.WORD_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_word_done: got %b want 0", bus_m.WORD_DONE); end
    n_cmp++; if (bus_m.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_m.BUSY); end
    n_cmp++; if (bus_m.DIN_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b want 0", bus_m.DIN_READY); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus_m.DIN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", bus_m.DIN_READY); end
    n_cmp++; if (bus_l.DIN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready_lsb: got %b want 1", bus_l.DIN_READY); end
    tick();
  endtask

  task automatic test_single_word();
    logic exp_bits [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bus_m.DIN       = 8'b1001_1000;
    bus_m.DIN_VALID = 1'b1;
    tick();
    bus_m.DIN_VALID = 1'b0;
    n_cmp++; if (bus_m.SO_VALID !== 1'b0) begin n_fail++; $display("FAIL single_latency: got %b want 0", bus_m.SO_VALID); end
    n_cmp++; if (bus_m.BUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy_held: got %b want 1", bus_m.BUSY); end
    n_cmp++; if (bus_m.DIN_READY !== 1'b0) begin n_fail++; $display("FAIL single_ready_full: got %b want 0", bus_m.DIN_READY); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (bus_m.SO !== exp_bits[k-1]) begin n_fail++; $display("FAIL single_so edge %0d: got %b want %b", k, bus_m.SO, exp_bits[k-1]); end
      n_cmp++; if (bus_m.SO_VALID !== 1'b1) begin n_fail++; $display("FAIL single_valid edge %0d: got %b want 1", k, bus_m.SO_VALID); end
      n_cmp++; if (bus_m.WORD_DONE !== (k == 8)) begin n_fail++; $display("FAIL single_done edge %0d: got %b want %b", k, bus_m.WORD_DONE, (k == 8)); end
    end
    tick();
    n_cmp++; if (bus_m.SO_VALID !== 1'b0) begin n_fail++; $display("FAIL single_end_valid: got %b want 0", bus_m.SO_VALID); end
    n_cmp++; if (bus_m.SO !== 1'b0) begin n_fail++; $display("FAIL single_end_so: got %b want 0", bus_m.SO); end
    n_cmp++; if (bus_m.BUSY !== 1'b0) begin n_fail++; $display("FAIL single_end_busy: got %b want 0", bus_m.BUSY); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_stream = 16'b1010_0101_0011_1100;
    bus_m.DIN       = 8'hA5;
    bus_m.DIN_VALID = 1'b1;
    tick();
    bus_m.DIN = 8'h3C;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++; if (bus_m.DIN_READY !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_xfer: got %b want 1", bus_m.DIN_READY); end
      end
      if (k == 2) bus_m.DIN_VALID = 1'b0;
      n_cmp++; if (bus_m.SO !== exp_stream[16-k]) begin n_fail++; $display("FAIL b2b_so edge %0d: got %b want %b", k, bus_m.SO, exp_stream[16-k]); end
      n_cmp++; if (bus_m.SO_VALID !== 1'b1) begin n_fail++; $display("FAIL b2b_valid edge %0d: got %b want 1", k, bus_m.SO_VALID); end
      n_cmp++; if (bus_m.WORD_DONE !== (k == 8 || k == 16)) begin n_fail++; $display("FAIL b2b_done edge %0d: got %b want %b", k, bus_m.WORD_DONE, (k == 8 || k == 16)); end
    end
    tick();
    n_cmp++; if (bus_m.SO_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b want 0", bus_m.SO_VALID); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  words [3]   = '{8'hC3, 8'h5A, 8'h0F};
    int          exp_acc [3] = '{0, 2, 10};
    int          acc_edge [3] = '{-1, -1, -1};
    int          idx  = 0;
    int          nvld = 0;
    logic [23:0] got  = '0;
    logic        fire;
    bus_m.DIN       = words[0];
    bus_m.DIN_VALID = 1'b1;
    for (int c = 0; c < 28; c++) begin
      fire = bus_m.DIN_VALID & bus_m.DIN_READY;
      tick();
      if (fire) begin
        acc_edge[idx] = c;
        idx++;
        if (idx < 3) bus_m.DIN = words[idx];
        else bus_m.DIN_VALID = 1'b0;
        n_cmp++; if (bus_m.DIN_READY !== 1'b0) begin n_fail++; $display("FAIL bp_ready_while_full edge %0d: got %b want 0", c, bus_m.DIN_READY); end
      end
      if (bus_m.SO_VALID === 1'b1) begin
        got = {got[22:0], bus_m.SO};
        nvld++;
      end
    end
    bus_m.DIN_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (acc_edge[i] !== exp_acc[i]) begin n_fail++; $display("FAIL bp_accept_edge word %0d: got %0d want %0d", i, acc_edge[i], exp_acc[i]); end
    end
    n_cmp++; if (got !== 24'hC35A0F) begin n_fail++; $display("FAIL bp_stream: got %h want c35a0f", got); end
    n_cmp++; if (nvld !== 24) begin n_fail++; $display("FAIL bp_valid_count: got %0d want 24", nvld); end
    n_cmp++; if (bus_m.BUSY !== 1'b0) begin n_fail++; $display("FAIL bp_end_busy: got %b want 0", bus_m.BUSY); end
  endtask

  task automatic test_lsb_first();
    bus_l.DIN       = 8'h01;
    bus_l.DIN_VALID = 1'b1;
    tick();
    bus_l.DIN_VALID = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (bus_l.SO !== (k == 1)) begin n_fail++; $display("FAIL lsb_so edge %0d: got %b want %b", k, bus_l.SO, (k == 1)); end
      n_cmp++; if (bus_l.SO_VALID !== 1'b1) begin n_fail++; $display("FAIL lsb_valid edge %0d: got %b want 1", k, bus_l.SO_VALID); end
      n_cmp++; if (bus_l.WORD_DONE !== (k == 8)) begin n_fail++; $display("FAIL lsb_done edge %0d: got %b want %b", k, bus_l.WORD_DONE, (k == 8)); end
    end
    tick();
    n_cmp++; if (bus_l.SO_VALID !== 1'b0) begin n_fail++; $display("FAIL lsb_end_valid: got %b want 0", bus_l.SO_VALID); end
  endtask

  task automatic test_reset_mid_word();
    bus_m.DIN       = 8'hFF;
    bus_m.DIN_VALID = 1'b1;
    tick();
    bus_m.DIN = 8'h81;
    tick();
    tick();
    bus_m.DIN_VALID = 1'b0;
    tick();
    n_cmp++; if (bus_m.SO_VALID !== 1'b1 || bus_m.SO !== 1'b1) begin n_fail++; $display("FAIL rstmid_bit3: got valid %b so %b want 1 1", bus_m.SO_VALID, bus_m.SO); end
    n_cmp++; if (bus_m.BUSY !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", bus_m.BUSY); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus_m.DIN_READY !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_in_rst: got %b want 0", bus_m.DIN_READY); end
    tick();
    n_cmp++; if (bus_m.SO !== 1'b0) begin n_fail++; $display("FAIL rstmid_so: got %b want 0", bus_m.SO); end
    n_cmp++; if (bus_m.SO_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", bus_m.SO_VALID); end
    n_cmp++; if (bus_m.WORD_DONE !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", bus_m.WORD_DONE); end
    n_cmp++; if (bus_m.BUSY !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus_m.BUSY); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus_m.DIN_READY !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_after: got %b want 1", bus_m.DIN_READY); end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++; if (bus_m.SO_VALID !== 1'b0 || bus_m.SO !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale cycle %0d: got valid %b so %b want 0 0", k, bus_m.SO_VALID, bus_m.SO); end
      n_cmp++; if (bus_m.BUSY !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_busy cycle %0d: got %b want 0", k, bus_m.BUSY); end
    end
  endtask

  task automatic test_idle_gap();
    bus_m.DIN       = 8'h5A;
    bus_m.DIN_VALID = 1'b1;
    tick();
    bus_m.DIN_VALID = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    n_cmp++; if (bus_m.WORD_DONE !== 1'b1 || bus_m.SO !== 1'b0) begin n_fail++; $display("FAIL gap_last_bit: got done %b so %b want 1 0", bus_m.WORD_DONE, bus_m.SO); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (bus_m.SO !== 1'b0) begin n_fail++; $display("FAIL gap_so cycle %0d: got %b want 0", k, bus_m.SO); end
      n_cmp++; if (bus_m.SO_VALID !== 1'b0) begin n_fail++; $display("FAIL gap_valid cycle %0d: got %b want 0", k, bus_m.SO_VALID); end
      n_cmp++; if (bus_m.BUSY !== 1'b0) begin n_fail++; $display("FAIL gap_busy cycle %0d: got %b want 0", k, bus_m.BUSY); end
    end
    bus_m.DIN       = 8'h80;
    bus_m.DIN_VALID = 1'b1;
    tick();
    bus_m.DIN_VALID = 1'b0;
    tick();
    n_cmp++; if (bus_m.SO_VALID !== 1'b1 || bus_m.SO !== 1'b1) begin n_fail++; $display("FAIL gap_restart: got valid %b so %b want 1 1", bus_m.SO_VALID, bus_m.SO); end
    tick();
    n_cmp++; if (bus_m.SO !== 1'b0) begin n_fail++; $display("FAIL gap_restart_bit2: got %b want 0", bus_m.SO); end
    for (int k = 0; k < 8; k++) tick();
  endtask

  initial begin
    bus_m.DIN       = '0;
    bus_m.DIN_VALID = 1'b0;
    bus_l.DIN       = '0;
    bus_l.DIN_VALID = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_lsb_first();
    test_reset_mid_word();
    test_idle_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
Upstream stage for the serial sequence detectors. Accepts parallel words over a valid/ready handshake and emits them one bit per clock on SO, which drives the detector's serial input I. A one-word holding buffer backs the shift register, so consecutive words stream with no idle gap. During gaps, SO carries a fixed idle level so the downstream detector sees defined data.

Parameters:
W, 8, word width in bits; legal range W >= 2.
MSB_FIRST, 1, 1 = bit W-1 is emitted first; 0 = bit 0 is emitted first.
IDLE_BIT, 0, value driven on SO whenever SO_VALID = 0.

Ports:
CLK  input  1  single clock; all state updates on posedge CLK.
RST  input  1  synchronous, active-high reset.
DIN  input  W  parallel word to serialise.
DIN_VALID  input  1  DIN holds a word.
DIN_READY  output  1  holding buffer is empty; this is combinational from hold_full, and is 0 while RST = 1.
SO  output  1  registered serial bit; connects to the detector input I.
SO_VALID  output  1  registered; SO carries a word bit this cycle.
WORD_DONE  output  1  registered; 1-cycle pulse coincident with the last bit of each word on SO.
BUSY  output  1  state is SHIFT or hold_full = 1.

Behaviour:
- Reset (RST = 1 at posedge): state = IDLE, hold_full = 0, bit counter = 0, SO = IDLE_BIT, SO_VALID = 0, WORD_DONE = 0.
- Reset mid-word discards both the shifting word and the held word. No partial-word completion and no WORD_DONE.
- Accept: DIN_VALID & DIN_READY at a posedge captures DIN into hold and sets hold_full = 1.
- DIN_VALID without DIN_READY does nothing. The producer holds DIN stable until accepted.
- State IDLE:
  - if hold_full = 1: at the next edge, load the shift register from hold, drive the first bit on SO, set SO_VALID = 1, set cnt = 1, clear hold_full, go to SHIFT.
  - otherwise: SO = IDLE_BIT, SO_VALID = 0.
- State SHIFT:
  - each edge drives the next bit on SO with SO_VALID = 1, and cnt increments.
  - the edge that drives bit W-1 (cnt = W-1 beforehand) also sets WORD_DONE = 1 and cnt = 0.
- End of word (the edge after the last bit has been driven):
  - if hold_full = 1: reload from hold in the same edge, drive its first bit, set cnt = 1, stay in SHIFT. This gives gapless back-to-back output.
  - otherwise: go to IDLE, with SO = IDLE_BIT and SO_VALID = 0.
- Latency: a word accepted at edge k puts its first bit on SO after edge k+1. The word occupies W consecutive SO_VALID cycles.
- Simultaneous events: an accept and a hold-to-shifter transfer cannot happen in the same edge, because DIN_READY = 0 whenever hold_full = 1. One word is accepted at most every cycle the hold is empty. A new accept may occur on the cycle after a transfer.
- Bit order: with MSB_FIRST = 1, bits go out in order W-1 down to 0. With MSB_FIRST = 0, bits go out in order 0 up to W-1.
- Counter: width is clog2(W). It never exceeds W-1; a count of W-1 wraps to 0 on the last bit.
- BUSY: 1 from the edge after an accept until the edge after the final word's last bit.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 1'b0, SHIFT = 1'b1;
  - a clog2-based counter-width function;
  - the default W.
- No sub-module is needed. The holding buffer, shifter and counter live in serial_bit_feeder.
- Top-level integration instantiates serial_bit_feeder with SO driving Sequence detector I, on the same CLK and RST.

Test Plan:
- Single word: W = 8, MSB_FIRST = 1, DIN = 8'b10011000 accepted at edge 0. Required: SO = 1,0,0,1,1,0,0,0 after edges 1–8, SO_VALID = 1 for those 8 cycles, WORD_DONE = 1 only after edge 8. The attached detector asserts Y one cycle after the fifth bit.
- Back-to-back: accept 8'hA5, then 8'h3C while the first word shifts. Required: 16 contiguous SO_VALID cycles with no idle bit between 10100101 and 00111100, and WORD_DONE after edges 8 and 16.
- Backpressure: DIN_VALID held high with three words queued. Required: DIN_READY = 0 while hold_full = 1; each word is accepted exactly once and in order; no word is lost or duplicated.
- LSB-first: MSB_FIRST = 0, DIN = 8'h01. Required: SO = 1,0,0,0,0,0,0,0.
- Reset mid-word: RST = 1 after bit 3 of 8'hFF with a second word held. Required: the next edge gives SO = IDLE_BIT, SO_VALID = 0, WORD_DONE = 0, BUSY = 0. After RST is released, DIN_READY = 1 and no stale bits appear.
- Idle gap: accept a word, then no DIN_VALID for 5 cycles. Required: SO = IDLE_BIT and SO_VALID = 0 for those 5 cycles, and BUSY = 0.
